apb_stream_completer: RTL and testbench

- APB completer (responder) at the far end of the byte-stream-to-APB initiator path.
- Decodes the 5-bit APB address space into:
  - 28 scratch registers,
  - a TX FIFO push port that drives an outgoing byte stream,
  - an RX FIFO pop port that drains an incoming byte stream,
  - a status register,
  - a read-only ID register.
- Inserts a parameterised number of wait states on every access.
- Used as the bus-side peripheral for loopback and system tests of the initiator.

---
 rtl/apb_stream_completer.sv | 115 +++++++++++
 tb/tb_apb_stream_completer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_stream_completer.sv
// APB completer: scratch registers, TX/RX byte-stream FIFOs, status and ID registers,
// with a fixed number of access-phase wait states on every transfer.
module apb_stream_completer #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [7:0]  ID_VALUE    = 8'hB5
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       PSEL,
    input  logic [4:0] PADDR,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready
);
    localparam int unsigned   PW    = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam logic [2:0]    WS    = 3'(WAIT_STATES);
    localparam logic [2:0]    DEPTH = 3'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST  = PW'(FIFO_DEPTH - 1);

    logic          live;
    logic [2:0]    wait_cnt;
    logic [7:0]    scratch [0:27];
    logic [7:0]    tx_mem  [0:FIFO_DEPTH-1];
    logic [7:0]    rx_mem  [0:FIFO_DEPTH-1];
    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [2:0]    tx_count, rx_count;
    logic          tx_overflow, rx_underflow;

    logic access, wr_done, rd_done, tx_full, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop, ovf_set, unf_set, stat_wr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        access    = PSEL & PENABLE;
        // live gates the bus outputs so nothing is driven during, or on the edge leaving, reset
        PREADY    = live & access & (wait_cnt == WS);
        wr_done   = PREADY & PWRITE;
        rd_done   = PREADY & ~PWRITE;
        tx_full   = (tx_count == DEPTH);
        rx_full   = (rx_count == DEPTH);
        rx_empty  = (rx_count == 3'd0);
        out_valid = (tx_count != 3'd0);
        out_data  = tx_mem[tx_rp];
        in_ready  = live & ~rx_full;
        tx_push   = wr_done & (PADDR == 5'd28) & ~tx_full;
        ovf_set   = wr_done & (PADDR == 5'd28) & tx_full;
        tx_pop    = out_valid & out_ready;
        rx_push   = in_valid & in_ready;
        rx_pop    = rd_done & (PADDR == 5'd29) & ~rx_empty;
        unf_set   = rd_done & (PADDR == 5'd29) & rx_empty;
        stat_wr   = wr_done & (PADDR == 5'd30);
        PRDATA    = '0;
        if (live & access & ~PWRITE) begin
            case (PADDR)
                5'd28:   PRDATA = '0;
                5'd29:   PRDATA = rx_empty ? '0 : rx_mem[rx_rp];
                5'd30:   PRDATA = {tx_overflow, rx_underflow, rx_count, tx_count};
                5'd31:   PRDATA = ID_VALUE;
                default: PRDATA = scratch[PADDR];
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            live         <= 1'b0;
            wait_cnt     <= '0;
            tx_wp        <= '0;
            tx_rp        <= '0;
            rx_wp        <= '0;
            rx_rp        <= '0;
            tx_count     <= '0;
            rx_count     <= '0;
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
            for (int unsigned i = 0; i < 28; i++) scratch[i] <= '0;
        end else begin
            live <= 1'b1;
            if (access) begin
                if (wait_cnt < WS) wait_cnt <= wait_cnt + 3'd1;
            end else begin
                wait_cnt <= '0;
            end
            if (wr_done && PADDR < 5'd28) scratch[PADDR] <= PWDATA;
            if (tx_push) tx_wp <= ptr_next(tx_wp);
            if (tx_pop)  tx_rp <= ptr_next(tx_rp);
            if (rx_push) rx_wp <= ptr_next(rx_wp);
            if (rx_pop)  rx_rp <= ptr_next(rx_rp);
            tx_count <= tx_count + {2'b0, tx_push} - {2'b0, tx_pop};
            rx_count <= rx_count + {2'b0, rx_push} - {2'b0, rx_pop};
            // a flag being raised on the same edge as its clear stays raised
            if (ovf_set) tx_overflow <= 1'b1;
            else if (stat_wr && PWDATA[7]) tx_overflow <= 1'b0;
            if (unf_set) rx_underflow <= 1'b1;
            else if (stat_wr && PWDATA[6]) rx_underflow <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wp] <= PWDATA;
        if (rx_push) rx_mem[rx_wp] <= in_data;
    end
endmodule

// File: tb/tb_apb_stream_completer.sv
// Bench for apb_stream_completer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized APB and stream traffic.
module tb_apb_stream_completer;
    localparam int         WS    = 2;
    localparam int         DEPTH = 4;
    localparam logic [7:0] ID    = 8'hB5;

    logic       CLK = 1'b0, RESETn = 1'b0;
    logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [4:0] PADDR = '0;
    logic [7:0] PWDATA = '0;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;

    int n_cmp = 0, n_bad = 0;
    bit rand_on = 1'b0;

    apb_stream_completer #(.WAIT_STATES(WS), .FIFO_DEPTH(DEPTH), .ID_VALUE(ID)) dut (
        .CLK(CLK), .RESETn(RESETn), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    always #5 CLK = ~CLK;

    // Reference model: register file, byte queues and flags.
    bit       m_en = 1'b0;
    int       m_acc = 0;
    bit [7:0] m_scr [28];
    bit [7:0] txq [$];
    bit [7:0] rxq [$];
    bit       m_ovf = 1'b0, m_unf = 1'b0;

    initial begin
        bit done, wr, rd, tx_pop, rx_push;
        int txn, rxn;
        forever begin
            @(posedge CLK or negedge RESETn);
            if (!RESETn) begin
                m_en = 1'b0; m_acc = 0; m_ovf = 1'b0; m_unf = 1'b0;
                foreach (m_scr[i]) m_scr[i] = 8'h00;
                txq.delete(); rxq.delete();
            end else begin
                done    = m_en && PSEL && PENABLE && (m_acc == WS);
                wr      = done && PWRITE;
                rd      = done && !PWRITE;
                txn     = txq.size();
                rxn     = rxq.size();
                tx_pop  = (txn != 0) && out_ready;
                rx_push = m_en && in_valid && (rxn != DEPTH);
                if (wr && PADDR < 5'd28) m_scr[PADDR] = PWDATA;
                if (tx_pop) void'(txq.pop_front());
                if (wr && PADDR == 5'd28 && txn < DEPTH) txq.push_back(PWDATA);
                if (rd && PADDR == 5'd29 && rxn != 0) void'(rxq.pop_front());
                if (rx_push) rxq.push_back(in_data);
                if (wr && PADDR == 5'd30 && PWDATA[7]) m_ovf = 1'b0;
                if (wr && PADDR == 5'd30 && PWDATA[6]) m_unf = 1'b0;
                if (wr && PADDR == 5'd28 && txn == DEPTH) m_ovf = 1'b1;
                if (rd && PADDR == 5'd29 && rxn == 0) m_unf = 1'b1;
                if (PSEL && PENABLE) begin
                    if (m_acc < WS) m_acc++;
                end else begin
                    m_acc = 0;
                end
                m_en = 1'b1;
            end
        end
    end

    function automatic logic [7:0] mread(input logic [4:0] a);
        if (a < 5'd28) return m_scr[a];
        case (a)
            5'd29:   return (rxq.size() != 0) ? rxq[0] : 8'h00;
            5'd30:   return {m_ovf, m_unf, 3'(rxq.size()), 3'(txq.size())};
            5'd31:   return ID;
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic acc_ph;
        acc_ph = m_en && PSEL && PENABLE;
        chk("PREADY", 32'(PREADY), 32'(acc_ph && m_acc == WS));
        chk("PRDATA", 32'(PRDATA), (acc_ph && !PWRITE) ? 32'(mread(PADDR)) : 32'h0);
        chk("out_valid", 32'(out_valid), 32'(txq.size() != 0));
        if (txq.size() != 0) chk("out_data", 32'(out_data), 32'(txq[0]));
        chk("in_ready", 32'(in_ready), 32'(m_en && rxq.size() != DEPTH));
    endtask

    task automatic tick();
        @(negedge CLK);
        compare_all();
        @(posedge CLK);
        #1;
        if (rand_on) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
        end
    endtask

    task automatic xfer(input logic w, input logic [4:0] a, input logic [7:0] d,
                        output logic [7:0] rdat, output int cyc);
        tick();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1'b1; rdat = '0; cyc = 0;
        forever begin
            cyc++;
            #1;
            if (PREADY) begin
                rdat = PRDATA;
                tick();
                break;
            end
            if (cyc >= 20) begin
                chk("wait_bound", 32'(cyc), 32'(WS + 1));
                tick();
                break;
            end
            tick();
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base, input int want, output int got);
        logic hs;
        in_valid = 1'b1; in_data = base; got = 0;
        for (int i = 0; i < 12 && got < want; i++) begin
            #1 hs = in_ready;
            tick();
            if (hs) begin got++; in_data = in_data + 8'd1; end
        end
    endtask

    logic [4:0] rd_addr [4] = '{5'd0, 5'd27, 5'd30, 5'd31};
    logic [7:0] rd_exp  [4] = '{8'h00, 8'h00, 8'h00, 8'hB5};

    initial begin
        logic [7:0] rdat;
        int cyc, got;

        repeat (3) tick();
        chk("rst_PREADY", 32'(PREADY), 32'h0);
        chk("rst_PRDATA", 32'(PRDATA), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        RESETn = 1'b1;
        #1 chk("in_ready_at_release", 32'(in_ready), 32'h0);
        tick();
        #1 chk("in_ready_after_release", 32'(in_ready), 32'h1);

        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, rd_addr[i], 8'h00, rdat, cyc);
            chk("reset_read_data", 32'(rdat), 32'(rd_exp[i]));
            chk("reset_read_cycles", 32'(cyc), 32'd3);
        end

        xfer(1'b1, 5'd3, 8'h5A, rdat, cyc);
        xfer(1'b0, 5'd3, 8'h00, rdat, cyc);
        chk("scratch3", 32'(rdat), 32'h5A);
        xfer(1'b1, 5'd31, 8'h11, rdat, cyc);
        xfer(1'b0, 5'd31, 8'h00, rdat, cyc);
        chk("id_after_write", 32'(rdat), 32'hB5);

        for (int i = 1; i <= 5; i++) xfer(1'b1, 5'd28, 8'(i), rdat, cyc);
        xfer(1'b0, 5'd30, 8'h00, rdat, cyc);
        chk("status_tx_overflow", 32'(rdat), 32'h84);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tx_drain_valid", 32'(out_valid), 32'h1);
            chk("tx_drain_data", 32'(out_data), 32'(k + 1));
            tick();
        end
        #1 chk("tx_drained", 32'(out_valid), 32'h0);
        out_ready = 1'b0;
        xfer(1'b1, 5'd30, 8'h80, rdat, cyc);
        xfer(1'b0, 5'd30, 8'h00, rdat, cyc);
        chk("status_after_w1c", 32'(rdat), 32'h00);

        fill(8'hA0, 5, got);
        chk("rx_accepts", 32'(got), 32'd4);
        chk("rx_full_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            xfer(1'b0, 5'd29, 8'h00, rdat, cyc);
            chk("rx_pop_data", 32'(rdat), (k < 4) ? 32'(8'hA0 + k) : 32'h0);
        end
        xfer(1'b0, 5'd30, 8'h00, rdat, cyc);
        chk("status_rx_underflow", 32'(rdat), 32'h40);
        xfer(1'b1, 5'd30, 8'h40, rdat, cyc);

        fill(8'hB0, 4, got);
        #1 chk("rx_full_again", 32'(in_ready), 32'h0);
        xfer(1'b0, 5'd29, 8'h00, rdat, cyc);
        chk("pop_while_full", 32'(rdat), 32'hB0);
        #1 chk("in_ready_after_pop", 32'(in_ready), 32'h1);
        in_valid = 1'b0;
        xfer(1'b0, 5'd30, 8'h00, rdat, cyc);
        chk("status_no_push_on_pop", 32'(rdat), 32'h18);
        for (int k = 1; k < 4; k++) begin
            xfer(1'b0, 5'd29, 8'h00, rdat, cyc);
            chk("rx_rest", 32'(rdat), 32'(8'hB0 + k));
        end

        rand_on = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a;
            a = ($urandom_range(0, 1) != 0) ? 5'(28 + $urandom_range(0, 3)) : 5'($urandom_range(0, 27));
            if ($urandom_range(0, 9) == 0) begin
                tick();
                PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'($urandom_range(0, 1));
                PADDR = a; PWDATA = 8'($urandom);
                tick();
                PENABLE = 1'b1;
                tick();
                PSEL = 1'b0; PENABLE = 1'b0;
            end else begin
                xfer(1'($urandom_range(0, 1)), a, 8'($urandom), rdat, cyc);
            end
        end
        rand_on = 1'b0;
        out_ready = 1'b0; in_valid = 1'b0;
        tick();

        xfer(1'b1, 5'd28, 8'h33, rdat, cyc);
        tick();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'd28; PWDATA = 8'h77;
        tick();
        PENABLE = 1'b1;
        tick();
        #2 RESETn = 1'b0;
        #1 chk("abort_PREADY", 32'(PREADY), 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        tick();
        RESETn = 1'b1;
        tick();
        #1 chk("abort_out_valid", 32'(out_valid), 32'h0);
        xfer(1'b0, 5'd30, 8'h00, rdat, cyc);
        chk("abort_status", 32'(rdat), 32'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
